// File: rtl/rr_lock_arbiter_x_in_pkg.sv
// Shared types and defaults for the round-robin packet-locking arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rr_lock_arbiter_x_in_pkg;

    // Default geometry: five router input ports, 3-bit index
    localparam int DEF_IO_SIZE = 5;
    localparam int DEF_IO_W    = 3;

    // Arbiter state: free arbitration, or grant pinned to a packet owner
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_lock_arbiter_x_in_if.sv
// Request/grant bundle between requesters and the arbiter.
// Latency: n/a (wires only).
// Backpressure: grant_accept from downstream qualifies each granted flit.
interface rr_lock_arbiter_x_in_if
    import rr_lock_arbiter_x_in_pkg::*;
#(
    parameter int IO_SIZE = DEF_IO_SIZE,
    parameter int IO_w    = DEF_IO_W
);
    logic [IO_SIZE-1:0] req;
    logic [IO_SIZE-1:0] tail;
    logic               grant_accept;
    logic [IO_SIZE-1:0] grant;
    logic [IO_w-1:0]    grant_id;
    logic               grant_valid;
    logic [IO_w-1:0]    token;
    logic               locked;

    // Requester / downstream side
    modport master (
        output req, tail, grant_accept,
        input  grant, grant_id, grant_valid, token, locked
    );

    // Arbiter side
    modport slave (
        input  req, tail, grant_accept,
        output grant, grant_id, grant_valid, token, locked
    );
endinterface

// File: rtl/rr_lock_arbiter_x_in_priority_select.sv
// Round-robin pick: rotate req by token, take lowest set bit, rotate back, encode.
// Latency: purely combinational.
// Backpressure: none; caller decides when a pick is consumed.
module rr_priority_select_x_in
    import rr_lock_arbiter_x_in_pkg::*;
#(
    parameter int IO_SIZE = DEF_IO_SIZE,
    parameter int IO_w    = DEF_IO_W
) (
    input  logic [IO_SIZE-1:0] req_i,
    input  logic [IO_w-1:0]    token_i,
    output logic [IO_SIZE-1:0] grant_o,
    output logic [IO_w-1:0]    grant_id_o
);
    logic [2*IO_SIZE-1:0] req_dbl;
    logic [2*IO_SIZE-1:0] req_shr;
    logic [IO_SIZE-1:0]   req_rot;
    logic [IO_SIZE-1:0]   pick_rot;
    logic [2*IO_SIZE-1:0] pick_shl;

    // Token position becomes bit 0, so fixed lowest-bit priority equals round-robin
    always_comb begin
        req_dbl  = {req_i, req_i};
        req_shr  = req_dbl >> token_i;
        req_rot  = req_shr[IO_SIZE-1:0];
        pick_rot = req_rot & (~req_rot + IO_SIZE'(1));
        pick_shl = {pick_rot, pick_rot} << token_i;
        grant_o  = pick_shl[2*IO_SIZE-1:IO_SIZE];
    end

    // One-hot to index; zero when nothing is granted
    always_comb begin
        grant_id_o = '0;
        for (int i = 0; i < IO_SIZE; i++) begin
            if (grant_o[i]) grant_id_o = IO_w'(i);
        end
    end
endmodule

// File: rtl/rr_lock_arbiter_x_in.sv
// Round-robin input-port arbiter; optional head-to-tail lock, token advances per packet.
// Latency: grant combinational from req; token/locked registered (next cycle).
// Backpressure: state only moves on grant_accept with a valid grant; otherwise holds.
module rr_lock_arbiter_x_in
    import rr_lock_arbiter_x_in_pkg::*;
#(
    parameter int IO_SIZE = DEF_IO_SIZE,
    parameter int IO_w    = DEF_IO_W,
    parameter bit LOCK_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_p,
    rr_lock_arbiter_x_in_if.slave arb
);
    arb_state_e         state_q, state_d;
    logic [IO_w-1:0]    owner_q, owner_d;
    logic [IO_w-1:0]    token_q, token_d;

    logic [IO_SIZE-1:0] sel_grant;
    logic [IO_w-1:0]    sel_id;
    logic [IO_SIZE-1:0] grant_c;
    logic [IO_w-1:0]    grant_id_c;
    logic               fire;

    rr_priority_select_x_in #(
        .IO_SIZE (IO_SIZE),
        .IO_w    (IO_w)
    ) u_sel (
        .req_i      (arb.req),
        .token_i    (token_q),
        .grant_o    (sel_grant),
        .grant_id_o (sel_id)
    );

    // While locked only the owner may win; a dropped owner request is a bubble
    always_comb begin
        grant_c    = sel_grant;
        grant_id_c = sel_id;
        if (state_q == ST_LOCKED) begin
            if (arb.req[owner_q]) begin
                grant_c    = IO_SIZE'(1) << owner_q;
                grant_id_c = owner_q;
            end else begin
                grant_c    = '0;
                grant_id_c = '0;
            end
        end
    end

    assign arb.grant       = grant_c;
    assign arb.grant_id    = grant_id_c;
    assign arb.grant_valid = |grant_c;
    assign arb.token       = token_q;
    assign arb.locked      = (state_q == ST_LOCKED);
    assign fire            = arb.grant_accept & arb.grant_valid;

    // Next state: token moves past the winner only when its tail is consumed
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        token_d = token_q;
        case (state_q)
            ST_IDLE: begin
                if (fire) begin
                    if (arb.tail[grant_id_c] || !LOCK_EN) begin
                        token_d = (grant_id_c == IO_w'(IO_SIZE - 1)) ? '0 : grant_id_c + IO_w'(1);
                    end else begin
                        owner_d = grant_id_c;
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (fire && arb.tail[owner_q]) begin
                    token_d = (owner_q == IO_w'(IO_SIZE - 1)) ? '0 : owner_q + IO_w'(1);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, owner and token registers with asynchronous reset
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            token_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            token_q <= token_d;
        end
    end
endmodule

// File: tb/tb_rr_lock_arbiter_x_in.sv
module tb_rr_lock_arbiter_x_in;
    logic clk;
    logic rst_p;
    int   checks;
    int   failures;

    typedef struct {
        bit         dut1;
        string      tag;
        logic [4:0] grant;
        logic [2:0] id;
        logic       vld;
        logic [2:0] tok;
        logic       lk;
    } exp_t;

    exp_t sb[$];

    rr_lock_arbiter_x_in_if #(.IO_SIZE(5), .IO_w(3)) a_if ();
    rr_lock_arbiter_x_in_if #(.IO_SIZE(5), .IO_w(3)) b_if ();

    rr_lock_arbiter_x_in #(.IO_SIZE(5), .IO_w(3), .LOCK_EN(1'b1)) u_lock (
        .clk   (clk),
        .rst_p (rst_p),
        .arb   (a_if)
    );

    rr_lock_arbiter_x_in #(.IO_SIZE(5), .IO_w(3), .LOCK_EN(1'b0)) u_nolock (
        .clk   (clk),
        .rst_p (rst_p),
        .arb   (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input string field, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
        end
    endtask

    task automatic push(input bit d1, input string tag, input int id, input bit vld, input int tok, input bit lk);
        exp_t e;
        e.dut1  = d1;
        e.tag   = tag;
        e.vld   = vld;
        e.id    = vld ? 3'(id) : 3'd0;
        e.grant = vld ? (5'b00001 << id) : 5'b00000;
        e.tok   = 3'(tok);
        e.lk    = lk;
        sb.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL sb_empty observed=0 expected=1");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.dut1) begin
                cmp(e.tag, "grant",  32'(b_if.grant),       32'(e.grant));
                cmp(e.tag, "id",     32'(b_if.grant_id),    32'(e.id));
                cmp(e.tag, "valid",  32'(b_if.grant_valid), 32'(e.vld));
                cmp(e.tag, "token",  32'(b_if.token),       32'(e.tok));
                cmp(e.tag, "locked", 32'(b_if.locked),      32'(e.lk));
            end else begin
                cmp(e.tag, "grant",  32'(a_if.grant),       32'(e.grant));
                cmp(e.tag, "id",     32'(a_if.grant_id),    32'(e.id));
                cmp(e.tag, "valid",  32'(a_if.grant_valid), 32'(e.vld));
                cmp(e.tag, "token",  32'(a_if.token),       32'(e.tok));
                cmp(e.tag, "locked", 32'(a_if.locked),      32'(e.lk));
            end
        end
    endtask

    // Sample on the falling edge, then move to just after the next rising edge
    task automatic step_chk();
        @(negedge clk);
        pop_cmp();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_p    = 1'b1;
        a_if.req = '0; a_if.tail = '0; a_if.grant_accept = 1'b0;
        b_if.req = '0; b_if.tail = '0; b_if.grant_accept = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_p = 1'b0;

        // Reset state
        push(0, "reset", 0, 0, 0, 0);
        step_chk();

        // Rotation: all request, all tail, accept every cycle
        a_if.req = 5'b11111; a_if.tail = 5'b11111; a_if.grant_accept = 1'b1;
        for (int k = 0; k < 6; k++) begin
            push(0, "rotate", k % 5, 1, k % 5, 0);
            step_chk();
        end
        a_if.grant_accept = 1'b0;
        push(0, "rotate_end", 1, 1, 1, 0);
        step_chk();

        // Lock: requester 1 sends 3 flits while requester 2 waits
        a_if.req = 5'b00110; a_if.tail = 5'b00000; a_if.grant_accept = 1'b1;
        push(0, "lock_head", 1, 1, 1, 0);
        step_chk();
        push(0, "lock_body", 1, 1, 1, 1);
        step_chk();
        a_if.tail = 5'b00010;
        push(0, "lock_tail", 1, 1, 1, 1);
        step_chk();
        a_if.tail = 5'b00000; a_if.grant_accept = 1'b0;
        push(0, "lock_after", 2, 1, 2, 0);
        step_chk();

        // Bubble: owner 3 drops request, requester 0 must stay masked
        a_if.req = 5'b01000; a_if.grant_accept = 1'b1;
        push(0, "bub_head", 3, 1, 2, 0);
        step_chk();
        a_if.req = 5'b00001;
        for (int k = 0; k < 2; k++) begin
            push(0, "bubble", 0, 0, 2, 1);
            step_chk();
        end
        a_if.req = 5'b01001; a_if.tail = 5'b01000;
        push(0, "bub_tail", 3, 1, 2, 1);
        step_chk();
        a_if.tail = 5'b00000; a_if.grant_accept = 1'b0;
        push(0, "bub_after", 0, 1, 4, 0);
        step_chk();

        // Enter a lock on requester 4, then reset asynchronously mid-cycle
        a_if.req = 5'b11111; a_if.grant_accept = 1'b1;
        push(0, "pre_rst", 4, 1, 4, 0);
        step_chk();
        a_if.grant_accept = 1'b0;
        push(0, "locked_4", 4, 1, 4, 1);
        step_chk();
        #2 rst_p = 1'b1;
        #1;
        push(0, "rst_mid", 0, 1, 0, 0);
        pop_cmp();
        @(posedge clk);
        #1 rst_p = 1'b0;
        push(0, "rst_rel", 0, 1, 0, 0);
        step_chk();

        // Stall: grant held without accept, token frozen
        a_if.req = 5'b01000; a_if.tail = 5'b01000; a_if.grant_accept = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push(0, "stall", 3, 1, 0, 0);
            step_chk();
        end
        a_if.grant_accept = 1'b1;
        push(0, "stall_acc", 3, 1, 0, 0);
        step_chk();
        a_if.req = 5'b00000;
        push(0, "idle_acc", 0, 0, 4, 0);
        step_chk();
        a_if.grant_accept = 1'b0;
        push(0, "idle_acc_tok", 0, 0, 4, 0);
        step_chk();

        // Lock disabled: tails ignored, grant alternates per flit
        b_if.req = 5'b00011; b_if.tail = 5'b00000; b_if.grant_accept = 1'b1;
        push(1, "nolock0", 0, 1, 0, 0);
        step_chk();
        push(1, "nolock1", 1, 1, 1, 0);
        step_chk();
        push(1, "nolock2", 0, 1, 2, 0);
        step_chk();
        push(1, "nolock3", 1, 1, 1, 0);
        step_chk();

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
